bh_key_msg_source: RTL
======================

Name: bh_key_msg_source

Overview:
- Upstream stage of the Bluetooth UART transmit path; drives the byte interface of `uart_send` (`enable` = `uart_en`, `dout` = `uart_din`).
- On each debounced press of the board key, emits a fixed 7-byte ASCII message "KEY:d\r\n". `d` is a decimal press counter.
- `uart_send` has no busy output, so bytes are paced by an internal inter-byte gap counter sized to cover one full UART frame plus guard time.

Parameters:
- DEBOUNCE_CYC, 1000000, cycles `key` must be stable before the change is accepted (20 ms at 50 MHz).
- BYTE_GAP_CYC, 57292, GAP-state cycles after each byte strobe (11 bit-times at 9600 baud, 50 MHz).

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- key  input  1  raw push-button, active-low (0 = pressed), asynchronous to sys_clk
- enable  output  1  one-cycle byte strobe to `uart_send` (`uart_en`)
- dout  output  8  byte to transmit, valid in the `enable` cycle and held until the next strobe
- busy  output  1  high while a message is in progress (SEND or GAP state)
- msg_done  output  1  one-cycle pulse when the last byte's gap completes

Behaviour:
- Reset values (asynchronous, immediate on `sys_rst`=1):
  - enable=0, dout=8'h00, busy=0, msg_done=0
  - sync flops=1, key_stable=1, debounce counter=0
  - state=IDLE, idx=0, gap counter=0, digit=8'h30 ('0')
- Synchroniser: `key` passes through 2 flops to give key_sync.
- Debounce:
  - If key_sync != key_stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, key_stable <= key_sync and the counter clears.
  - Any cycle with key_sync == key_stable clears the counter.
- Press event: one-cycle pulse when key_stable goes 1->0. A release generates no event.
- Message bytes, in order by idx 0..6: 8'h4B, 8'h45, 8'h59, 8'h3A, digit, 8'h0D, 8'h0A.
- FSM, states IDLE / SEND / GAP:
  - IDLE: on press event -> SEND with idx=0. busy=0.
  - SEND (exactly 1 cycle): enable=1, dout=byte[idx] (registered outputs, so both appear in the same cycle), gap counter cleared -> GAP.
  - GAP: gap counter increments from 0. At BYTE_GAP_CYC-1:
    - if idx==6: -> IDLE, msg_done=1 for one cycle, digit increments;
    - else: idx+1 -> SEND.
- Digit counts 8'h30..8'h39 and wraps 8'h39 -> 8'h30. It updates only at msg_done, so a message in flight carries a stable digit.
- Timing:
  - enable rises 1 cycle after the press-event cycle.
  - Strobe-to-strobe spacing is BYTE_GAP_CYC+1 cycles.
  - A full message spans 7*(BYTE_GAP_CYC+1) cycles from the first strobe to msg_done.
  - msg_done coincides with the return to IDLE.
- Press events while busy=1 are dropped; there is no queueing.
- A press event in the same cycle as the final GAP->IDLE transition is also dropped. A new message needs a later press event.
- busy=1 from the first SEND cycle through the last GAP cycle.
- Reset mid-message aborts immediately:
  - no further strobes are issued;
  - digit returns to '0';
  - the next press starts a fresh message from idx 0.
- dout keeps 8'h0A after a completed message until the next strobe.

Test Plan (DEBOUNCE_CYC=4, BYTE_GAP_CYC=10):
- Reset check: assert sys_rst, key=1 -> enable=0, dout=00, busy=0, msg_done=0. Release reset, idle 50 cycles -> no strobe.
- Single press: hold key=0 for 20 cycles -> exactly 7 enable pulses 11 cycles apart with dout 4B,45,59,3A,30,0D,0A. msg_done pulses once, 11 cycles after the 7th strobe. busy drops in that same cycle.
- Bounce rejection: toggle key 0/1 every 2 cycles for 40 cycles, then hold key=1 -> no strobe. Glitches shorter than 4 stable cycles are never accepted.
- Digit wrap: 11 separated presses -> the 5th byte of successive messages reads 30,31,…,39,30.
- Press while busy: a second press (release, then press again) during message 1 -> only 7 strobes total. The next message after completion carries digit 31.
- Reset mid-message: assert sys_rst after the 3rd strobe -> enable=0 immediately and no 4th strobe. The next press sends a full message with digit 30.

Source files
------------

// File: rtl/bh_key_msg_source.sv
// Key-press message source for the Bluetooth UART transmit path.
// Each debounced key press sends "KEY:d\r\n" byte by byte, paced by an inter-byte gap.
module bh_key_msg_source #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BYTE_GAP_CYC = 57292
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key,
    output logic       enable,
    output logic [7:0] dout,
    output logic       busy,
    output logic       msg_done
);

    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int GAP_W = (BYTE_GAP_CYC > 1) ? $clog2(BYTE_GAP_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(BYTE_GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic             sync1_r, sync2_r;
    logic             key_stable_r, key_stable_d_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             press_s;

    state_t           state_r, state_nx_s;
    logic [2:0]       idx_r, idx_nx_s;
    logic [GAP_W-1:0] gap_r, gap_nx_s;
    logic [7:0]       digit_r, digit_nx_s;
    logic             enable_r, enable_nx_s;
    logic [7:0]       dout_r, dout_nx_s;
    logic             busy_r, busy_nx_s;
    logic             msg_done_r, msg_done_nx_s;

    function automatic logic [7:0] msg_byte(input logic [2:0] i, input logic [7:0] d);
        case (i)
            3'd0:    msg_byte = 8'h4B;
            3'd1:    msg_byte = 8'h45;
            3'd2:    msg_byte = 8'h59;
            3'd3:    msg_byte = 8'h3A;
            3'd4:    msg_byte = d;
            3'd5:    msg_byte = 8'h0D;
            3'd6:    msg_byte = 8'h0A;
            default: msg_byte = 8'h00;
        endcase
    endfunction

    // Synchronise the raw key and accept a new level only after it has held long enough.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_r        <= 1'b1;
            sync2_r        <= 1'b1;
            key_stable_r   <= 1'b1;
            key_stable_d_r <= 1'b1;
            deb_cnt_r      <= {DEB_W{1'b0}};
        end else begin
            sync1_r        <= key;
            sync2_r        <= sync1_r;
            key_stable_d_r <= key_stable_r;
            if (sync2_r != key_stable_r) begin
                if (deb_cnt_r == DEB_MAX) begin
                    key_stable_r <= sync2_r;
                    deb_cnt_r    <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                end
            end else begin
                deb_cnt_r <= {DEB_W{1'b0}};
            end
        end
    end

    // Only the falling edge of the stable level is a press; release is ignored.
    assign press_s = key_stable_d_r & ~key_stable_r;

    // Next-state and next-output decode for the byte sequencer.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        gap_nx_s      = gap_r;
        digit_nx_s    = digit_r;
        enable_nx_s   = 1'b0;
        dout_nx_s     = dout_r;
        msg_done_nx_s = 1'b0;
        busy_nx_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_s) begin
                    state_nx_s  = SEND;
                    idx_nx_s    = 3'd0;
                    enable_nx_s = 1'b1;
                    dout_nx_s   = msg_byte(3'd0, digit_r);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                state_nx_s = GAP;
                gap_nx_s   = {GAP_W{1'b0}};
            end
            GAP: begin
                if (gap_r == GAP_MAX) begin
                    if (idx_r == 3'd6) begin
                        state_nx_s    = IDLE;
                        msg_done_nx_s = 1'b1;
                        digit_nx_s    = (digit_r == 8'h39) ? 8'h30 : digit_r + 8'd1;
                    end else begin
                        state_nx_s  = SEND;
                        idx_nx_s    = idx_r + 3'd1;
                        enable_nx_s = 1'b1;
                        dout_nx_s   = msg_byte(idx_nx_s, digit_r);
                    end
                end else begin
                    gap_nx_s = gap_r + GAP_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                idx_nx_s   = 3'd0;
                gap_nx_s   = {GAP_W{1'b0}};
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // Sequencer state and registered outputs; outputs line up with the state they describe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= IDLE;
            idx_r      <= 3'd0;
            gap_r      <= {GAP_W{1'b0}};
            digit_r    <= 8'h30;
            enable_r   <= 1'b0;
            dout_r     <= 8'h00;
            busy_r     <= 1'b0;
            msg_done_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            idx_r      <= idx_nx_s;
            gap_r      <= gap_nx_s;
            digit_r    <= digit_nx_s;
            enable_r   <= enable_nx_s;
            dout_r     <= dout_nx_s;
            busy_r     <= busy_nx_s;
            msg_done_r <= msg_done_nx_s;
        end
    end

    assign enable   = enable_r;
    assign dout     = dout_r;
    assign busy     = busy_r;
    assign msg_done = msg_done_r;

endmodule
